cdc_synchronizer: RTL and testbench

CDC_SYNCHRONIZER -- requirements
Module: cdc_synchronizer

---
 rtl/cdc_synchronizer_if.sv | 19 +
 rtl/cdc_synchronizer.sv | 89 ++++++++
 tb/tb_cdc_synchronizer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cdc_synchronizer_if.sv
// rtl/cdc_synchronizer_if.sv - data/status bundle for cdc_synchronizer
// o_gray_err exists only when CDC_SYNC_GRAY_CHECK_EN is defined.
interface cdc_synchronizer_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] i_input_data;
  logic [WIDTH-1:0] o_output_data;
  logic             o_valid;
  logic             o_changed;
`ifdef CDC_SYNC_GRAY_CHECK_EN
  logic             o_gray_err;

  modport master (output i_input_data, input o_output_data, o_valid, o_changed, o_gray_err);
  modport slave  (input i_input_data, output o_output_data, o_valid, o_changed, o_gray_err);
`else
  modport master (output i_input_data, input o_output_data, o_valid, o_changed);
  modport slave  (input i_input_data, output o_output_data, o_valid, o_changed);
`endif
endinterface

// File: rtl/cdc_synchronizer.sv
// rtl/cdc_synchronizer.sv - multi-stage per-bit synchronizer with fill tracking and change pulse
// Optional gray-code multi-bit-change checker compiled in with CDC_SYNC_GRAY_CHECK_EN.
module cdc_synchronizer #(
  parameter int               WIDTH       = 6,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              i_wclk,
  input  logic              i_rst_n,
  cdc_synchronizer_if.slave bus
);
  localparam int             CW   = $clog2(STAGES + 1);
  localparam logic [CW-1:0]  FULL = CW'(STAGES);

  generate
    if (STAGES < 2 || WIDTH < 1) begin : g_param_check
      $error("cdc_synchronizer: requires STAGES >= 2 and WIDTH >= 1");
    end
  endgenerate

  // Index 0 samples the foreign domain; index STAGES-1 drives the output.
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] stage_q;

  logic [CW-1:0] fill_q;
  logic [CW-1:0] fill_d;
  logic          valid_d;
  logic          changed_q;

  always_ff @(posedge i_wclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_q <= {STAGES{RESET_VALUE}};
    end else begin
      stage_q <= {stage_q[STAGES-2:0], bus.i_input_data};
    end
  end

  always_comb begin
    fill_d = fill_q;
    if (fill_q != FULL) begin
      fill_d = fill_q + CW'(1);
    end
    valid_d = (fill_d == FULL);
  end

  // The pulse describes the value the last stage takes on this same edge.
  always_ff @(posedge i_wclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fill_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      fill_q    <= fill_d;
      changed_q <= valid_d && (stage_q[STAGES-2] != stage_q[STAGES-1]);
    end
  end

  assign bus.o_output_data = stage_q[STAGES-1];
  assign bus.o_valid       = (fill_q == FULL);
  assign bus.o_changed     = changed_q;

`ifdef CDC_SYNC_GRAY_CHECK_EN
  logic [WIDTH-1:0] last_prev_q;
  logic [WIDTH-1:0] diff;
  logic             multi_bit;
  logic             valid_prev_q;
  logic             gray_err_q;

  // Both compared values must be post-reset samples, so the fill step is ignored.
  always_comb begin
    diff      = stage_q[STAGES-1] ^ last_prev_q;
    multi_bit = |(diff & (diff - WIDTH'(1)));
  end

  always_ff @(posedge i_wclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_prev_q  <= RESET_VALUE;
      valid_prev_q <= 1'b0;
      gray_err_q   <= 1'b0;
    end else begin
      last_prev_q  <= stage_q[STAGES-1];
      valid_prev_q <= bus.o_valid;
      if (bus.o_valid && valid_prev_q && multi_bit) begin
        gray_err_q <= 1'b1;
      end
    end
  end

  assign bus.o_gray_err = gray_err_q;
`endif
endmodule

// File: tb/tb_cdc_synchronizer.sv
// tb/tb_cdc_synchronizer.sv - directed table-driven bench for cdc_synchronizer
// Gray-error checks are active when CDC_SYNC_GRAY_CHECK_EN is defined.
module tb_cdc_synchronizer;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cdc_synchronizer_if #(.WIDTH(6)) bus_a ();
  cdc_synchronizer_if #(.WIDTH(6)) bus_b ();

  cdc_synchronizer #(.WIDTH(6), .STAGES(2), .RESET_VALUE(6'h00)) dut_a (
    .i_wclk (clk),
    .i_rst_n(rst_n),
    .bus    (bus_a)
  );

  cdc_synchronizer #(.WIDTH(6), .STAGES(4), .RESET_VALUE(6'h00)) dut_b (
    .i_wclk (clk),
    .i_rst_n(rst_n),
    .bus    (bus_b)
  );

  typedef struct {
    bit         use_b;
    logic [5:0] din;
    logic [5:0] dout;
    logic       valid;
    logic       changed;
    logic       gerr;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(bit b, logic [5:0] di, logic [5:0] dq, logic v, logic c, logic g);
    vecs.push_back('{b, di, dq, v, c, g});
  endfunction

  task automatic check(string name, int idx, logic [5:0] act, logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_table(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      logic [5:0] q;
      logic       v, c;
      logic       g;
      if (vecs[i].use_b) bus_b.i_input_data = vecs[i].din;
      else               bus_a.i_input_data = vecs[i].din;
      tick();
      q = vecs[i].use_b ? bus_b.o_output_data : bus_a.o_output_data;
      v = vecs[i].use_b ? bus_b.o_valid       : bus_a.o_valid;
      c = vecs[i].use_b ? bus_b.o_changed     : bus_a.o_changed;
      check("vec_out",     i, q, vecs[i].dout);
      check("vec_valid",   i, {5'b0, v}, {5'b0, vecs[i].valid});
      check("vec_changed", i, {5'b0, c}, {5'b0, vecs[i].changed});
`ifdef CDC_SYNC_GRAY_CHECK_EN
      g = vecs[i].use_b ? bus_b.o_gray_err : bus_a.o_gray_err;
      check("vec_gray_err", i, {5'b0, g}, {5'b0, vecs[i].gerr});
`else
      g = 1'b0;
`endif
    end
  endtask

  initial begin
    int a_lo, a_hi, b_lo, b_hi;

    // DUT A (STAGES=2): reset fill, single-bit walk back to 0, latency, gray count, gray error
    a_lo = 0;
    add(0, 6'h2A, 6'h00, 0, 0, 0);
    add(0, 6'h2A, 6'h2A, 1, 1, 0);
    add(0, 6'h28, 6'h2A, 1, 0, 0);
    add(0, 6'h20, 6'h28, 1, 1, 0);
    add(0, 6'h00, 6'h20, 1, 1, 0);
    add(0, 6'h00, 6'h00, 1, 1, 0);
    add(0, 6'h00, 6'h00, 1, 0, 0);
    add(0, 6'h01, 6'h00, 1, 0, 0);
    add(0, 6'h01, 6'h01, 1, 1, 0);
    add(0, 6'h01, 6'h01, 1, 0, 0);
    add(0, 6'h00, 6'h01, 1, 0, 0);
    add(0, 6'h00, 6'h00, 1, 1, 0);
    add(0, 6'h00, 6'h00, 1, 0, 0);
    add(0, 6'h01, 6'h00, 1, 0, 0);
    add(0, 6'h03, 6'h01, 1, 1, 0);
    add(0, 6'h02, 6'h03, 1, 1, 0);
    add(0, 6'h06, 6'h02, 1, 1, 0);
    add(0, 6'h07, 6'h06, 1, 1, 0);
    add(0, 6'h05, 6'h07, 1, 1, 0);
    add(0, 6'h04, 6'h05, 1, 1, 0);
    add(0, 6'h04, 6'h04, 1, 1, 0);
    add(0, 6'h04, 6'h04, 1, 0, 0);
    add(0, 6'h00, 6'h04, 1, 0, 0);
    add(0, 6'h00, 6'h00, 1, 1, 0);
    add(0, 6'h00, 6'h00, 1, 0, 0);
    add(0, 6'h03, 6'h00, 1, 0, 0);
    add(0, 6'h03, 6'h03, 1, 1, 0);
    add(0, 6'h03, 6'h03, 1, 0, 1);
    add(0, 6'h03, 6'h03, 1, 0, 1);
    a_hi = vecs.size() - 1;

    // DUT B (STAGES=4): fill to valid, then step 03 -> 02
    b_lo = vecs.size();
    add(1, 6'h03, 6'h00, 0, 0, 0);
    add(1, 6'h03, 6'h00, 0, 0, 0);
    add(1, 6'h03, 6'h00, 0, 0, 0);
    add(1, 6'h03, 6'h03, 1, 1, 0);
    add(1, 6'h03, 6'h03, 1, 0, 0);
    add(1, 6'h02, 6'h03, 1, 0, 0);
    add(1, 6'h02, 6'h03, 1, 0, 0);
    add(1, 6'h02, 6'h03, 1, 0, 0);
    add(1, 6'h02, 6'h02, 1, 1, 0);
    add(1, 6'h02, 6'h02, 1, 0, 0);
    b_hi = vecs.size() - 1;

    rst_n = 1'b0;
    bus_a.i_input_data = 6'h2A;
    bus_b.i_input_data = 6'h03;
    #1;
    check("por_out",   0, bus_a.o_output_data, 6'h00);
    check("por_valid", 0, {5'b0, bus_a.o_valid}, 6'h00);
    tick();
    tick();
    check("rst_hold_out", 0, bus_a.o_output_data, 6'h00);

    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("pre_pulse_out", 0, bus_a.o_output_data, 6'h2A);

    // Reset pulse between edges must clear everything without a clock
    #2 rst_n = 1'b0;
    #1;
    check("pulse_out",     0, bus_a.o_output_data, 6'h00);
    check("pulse_valid",   0, {5'b0, bus_a.o_valid}, 6'h00);
    check("pulse_changed", 0, {5'b0, bus_a.o_changed}, 6'h00);
    check("pulse_b_out",   0, bus_b.o_output_data, 6'h00);
    @(negedge clk);
    check("pulse_hold_out", 0, bus_a.o_output_data, 6'h00);
    rst_n = 1'b1;
    run_table(a_lo, a_hi);

    #2 rst_n = 1'b0;
    #1;
`ifdef CDC_SYNC_GRAY_CHECK_EN
    check("gray_err_clear", 0, {5'b0, bus_a.o_gray_err}, 6'h00);
`endif
    check("clear_out", 0, bus_a.o_output_data, 6'h00);
    @(negedge clk);
    rst_n = 1'b1;
    run_table(b_lo, b_hi);

    // Mid-propagation reset: the in-flight 15 must never reach the output
    bus_a.i_input_data = 6'h3C;
    tick();
    tick();
    tick();
    check("mid_settled", 0, bus_a.o_output_data, 6'h3C);
    bus_a.i_input_data = 6'h15;
    tick();
    check("mid_inflight", 0, bus_a.o_output_data, 6'h3C);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out",   0, bus_a.o_output_data, 6'h00);
    check("mid_rst_valid", 0, {5'b0, bus_a.o_valid}, 6'h00);
    bus_a.i_input_data = 6'h0C;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mid_post1_out",   1, bus_a.o_output_data, 6'h00);
    check("mid_post1_valid", 1, {5'b0, bus_a.o_valid}, 6'h00);
    tick();
    check("mid_post2_out",     2, bus_a.o_output_data, 6'h0C);
    check("mid_post2_changed", 2, {5'b0, bus_a.o_changed}, 6'h01);
    tick();
    check("mid_post3_out",     3, bus_a.o_output_data, 6'h0C);
    check("mid_post3_changed", 3, {5'b0, bus_a.o_changed}, 6'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
